adq_sample_buffer: RTL and testbench
====================================

// Module: adq_sample_buffer
// PURPOSE
// - Sample store directly downstream of the acquisition controller.
// - Captures one ADC word on each controller W strobe, at an internal address counter.
// - Reports counter value and full flag back to the controller (COUNT / add_count_f).
// - Drains stored samples to the host over a valid/ready stream, oldest first.
// PARAMETERS
// - DATA_W  8   ADC sample width
// - DEPTH  16   number of sample words; must be a power of 2, >= 2
// - ADDR_W  4   clog2(DEPTH)
// PORTS
// - clk          in   1         clock, rising edge
// - rst          in   1         reset, asynchronous, active-high
// - adc_data     in   DATA_W    ADC conversion result, valid while wr=1
// - wr           in   1         write strobe (controller W), 1 cycle per sample
// - cc           in   1         clear counter (controller CC)
// - count        out  ADDR_W+1  number of stored samples, 0..DEPTH
// - add_count_f  out  1         buffer full: count==DEPTH
// - rd_start     in   1         host request to drain buffer
// - rd_valid     out  1         rd_data valid
// - rd_ready     in   1         host accepts rd_data
// - rd_data      out  DATA_W    stored sample, registered
// - rd_last      out  1         qualifies final word of drain
// - busy         out  1         drain in progress (state==DRAIN)
// BEHAVIOUR
// - Reset values: state FILL, count 0, rd ptr 0, rd_valid 0, rd_data 0, rd_last 0, busy 0, add_count_f 0.
// - Memory contents are not reset.
// - States: FILL (accept writes), DRAIN (stream out). No other states; any illegal encoding returns to FILL.
// - FILL, wr=1, count<DEPTH: mem[count]<=adc_data; count<=count+1 on the same edge.
// - FILL, wr=1, count==DEPTH: write dropped, count holds (no wrap).
// - add_count_f is combinational from the count register: high from the cycle after the DEPTH-th write.
// - cc=1 in FILL: count<=0. If cc and wr occur in the same cycle, cc wins and the write is dropped.
// - rd_start=1 in FILL with count>0: enter DRAIN, rd ptr<=0. Writes in that same cycle are dropped.
// - rd_start=1 with count==0: ignored.
// - DRAIN: rd_valid and rd_data are registered.
//   - First rd_valid is 1 cycle after the rd_start edge, with rd_data=mem[0].
//   - Transfer happens on rd_valid & rd_ready. The next word appears the following cycle, so 1 word/cycle is possible with rd_ready held high.
//   - While rd_ready=0, rd_valid, rd_data and rd_last hold stable.
//   - rd_last=1 with the word at index count-1.
//   - After the last transfer: count<=0, state<=FILL, rd_valid<=0.
// - DRAIN: wr and rd_start are ignored.
// - DRAIN: cc=1 aborts. rd_valid<=0, count<=0, state<=FILL next edge; the pending word is discarded.
// - busy=1 exactly while in DRAIN. The controller must not issue W while busy=1.
// - rst mid-fill or mid-drain: all outputs return to reset values immediately (asynchronous).
// CONFIGURATION
// - Macro ADQ_SAMPLE_BUFFER_OVF_EN.
// - Defined: adds output port ovf (1 bit, reset 0).
//   - ovf is sticky; it is set on any wr that is dropped because the buffer is full, or because the block is in DRAIN.
//   - ovf is cleared only by cc or rst.
// - Undefined: no ovf port. Dropped writes are silent. All other behaviour is identical.
// TESTING
// - Reset: assert rst mid-cycle -> all outputs 0 asynchronously, count=0.
// - Fill: 16 wr with adc_data=0x10..0x1F -> count 1..16, add_count_f=1 after the 16th.
//   - A 17th wr leaves count=16 (ovf=1 if OVF_EN).
// - Drain, rd_ready=1: rd_start after 3 writes (0xA1,0xB2,0xC3).
//   - rd_valid high 1 cycle later; data 0xA1,0xB2,0xC3 on consecutive cycles; rd_last with 0xC3.
//   - Then count=0, busy=0.
// - Backpressure: 2 samples, rd_ready toggling 0/1 every cycle.
//   - Each word held stable while rd_ready=0; exactly 2 transfers; no duplicates.
// - Simultaneous cc+wr at count=5 -> count=0 next cycle, no write. cc during DRAIN -> rd_valid=0, FILL, count=0.
// - rd_start with count=0 -> stays FILL, rd_valid stays 0. wr during DRAIN -> count unchanged after drain completes.

Source files
------------

// File: rtl/adq_sample_buffer_if.sv
// Controller-side and host-side signal bundle for adq_sample_buffer.
// The ovf signal exists only when ADQ_SAMPLE_BUFFER_OVF_EN is defined.
interface adq_sample_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] adc_data;
    logic              wr;
    logic              cc;
    logic [ADDR_W:0]   count;
    logic              add_count_f;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
`ifdef ADQ_SAMPLE_BUFFER_OVF_EN
    logic              ovf;

    modport master (
        output adc_data, wr, cc, rd_start, rd_ready,
        input  count, add_count_f, rd_valid, rd_data, rd_last, busy, ovf
    );
    modport slave (
        input  adc_data, wr, cc, rd_start, rd_ready,
        output count, add_count_f, rd_valid, rd_data, rd_last, busy, ovf
    );
`else
    modport master (
        output adc_data, wr, cc, rd_start, rd_ready,
        input  count, add_count_f, rd_valid, rd_data, rd_last, busy
    );
    modport slave (
        input  adc_data, wr, cc, rd_start, rd_ready,
        output count, add_count_f, rd_valid, rd_data, rd_last, busy
    );
`endif
endinterface

// File: rtl/adq_sample_buffer.sv
// ADC sample store: fills on controller strobes, drains oldest-first over valid/ready.
// Optional sticky overflow flag enabled by macro ADQ_SAMPLE_BUFFER_OVF_EN.
module adq_sample_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    adq_sample_buffer_if.slave bus
);
    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_we_s;
    logic [ADDR_W:0]   ptr_nxt_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Next-state and datapath decisions; rd_ptr_q indexes the word currently presented
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        mem_we_s   = 1'b0;
        ptr_nxt_s  = {1'b0, rd_ptr_q} + CNT_ONE;
        case (state_q)
            S_FILL: begin
                if (bus.cc) begin
                    count_d = {(ADDR_W+1){1'b0}};
                end else if (bus.rd_start && (count_q != {(ADDR_W+1){1'b0}})) begin
                    state_d    = S_DRAIN;
                    rd_ptr_d   = {ADDR_W{1'b0}};
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem_q[{ADDR_W{1'b0}}];
                    rd_last_d  = (count_q == CNT_ONE);
                end else if (bus.wr && (count_q != FULL_CNT)) begin
                    mem_we_s = 1'b1;
                    count_d  = count_q + CNT_ONE;
                end else begin
                    count_d = count_q;
                end
            end
            S_DRAIN: begin
                if (bus.cc) begin
                    state_d    = S_FILL;
                    count_d    = {(ADDR_W+1){1'b0}};
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end else if (rd_valid_q && bus.rd_ready) begin
                    if (rd_last_q) begin
                        state_d    = S_FILL;
                        count_d    = {(ADDR_W+1){1'b0}};
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        rd_ptr_d  = ptr_nxt_s[ADDR_W-1:0];
                        rd_data_d = mem_q[ptr_nxt_s[ADDR_W-1:0]];
                        rd_last_d = ((ptr_nxt_s + CNT_ONE) == count_q);
                    end
                end else begin
                    rd_valid_d = rd_valid_q;
                end
            end
            default: begin
                state_d    = S_FILL;
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, read pointer and registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= {(ADDR_W+1){1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Sample storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[count_q[ADDR_W-1:0]] <= bus.adc_data;
        end
    end

`ifdef ADQ_SAMPLE_BUFFER_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky flag for writes lost to a full buffer or to an active drain
    always_comb begin
        ovf_d = ovf_q;
        if (bus.cc) begin
            ovf_d = 1'b0;
        end else if (bus.wr && (state_q == S_DRAIN)) begin
            ovf_d = 1'b1;
        end else if (bus.wr && (count_q == FULL_CNT) && !bus.rd_start) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.count       = count_q;
    assign bus.add_count_f = (count_q == FULL_CNT);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.busy        = (state_q == S_DRAIN);
endmodule

// File: tb/tb_adq_sample_buffer.sv
// Self-checking bench for adq_sample_buffer: vector table for fill/clear cases,
// scoreboard queue for drains; ovf checks follow ADQ_SAMPLE_BUFFER_OVF_EN.
module tb_adq_sample_buffer;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adq_sample_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    adq_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       wr;
        logic       cc;
        logic       rd_start;
        logic [7:0] data;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_busy;
        logic       exp_valid;
        logic       exp_ovf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         mcnt        = 0;
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic cc, input logic rs, input logic [7:0] d,
                                input logic [4:0] c, input logic f, input logic o);
        vec_t v;
        v.wr = wr; v.cc = cc; v.rd_start = rs; v.data = d;
        v.exp_count = c; v.exp_full = f; v.exp_busy = 1'b0; v.exp_valid = 1'b0; v.exp_ovf = o;
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; model count decides whether the word is stored
    task automatic wr_word(input logic [7:0] d);
        bus.wr = 1'b1;
        bus.adc_data = d;
        cycle();
        bus.wr = 1'b0;
        if (mcnt < DEPTH) begin
            sb.push_back(d);
            mcnt++;
        end
        chk("wr_count", {27'd0, bus.count}, mcnt);
    endtask

    // Start a drain and consume it; toggle=rd_ready alternates 0/1, inject=wr on first drain cycle
    task automatic drain(input bit toggle, input bit inject);
        int c = 0;
        bus.rd_start = 1'b1;
        bus.rd_ready = 1'b0;
        cycle();
        bus.rd_start = 1'b0;
        chk("busy_in_drain", {31'd0, bus.busy}, 32'd1);
        while (sb.size() > 0 && c < 64) begin
            bus.wr       = inject && (c == 0);
            bus.adc_data = 8'h55;
            bus.rd_ready = toggle ? c[0] : !(inject && (c == 0));
            chk("drain_valid", {31'd0, bus.rd_valid}, 32'd1);
            chk("drain_data", {24'd0, bus.rd_data}, {24'd0, sb[0]});
            chk("drain_last", {31'd0, bus.rd_last}, {31'd0, (sb.size() == 1)});
            if (bus.rd_ready) begin
                void'(sb.pop_front());
            end
            cycle();
            c++;
        end
        bus.wr       = 1'b0;
        bus.rd_ready = 1'b0;
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
        end
        mcnt = 0;
        chk("post_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("post_busy", {31'd0, bus.busy}, 32'd0);
        chk("post_count", {27'd0, bus.count}, 32'd0);
    endtask

    initial begin
        bus.adc_data = 8'h00;
        bus.wr       = 1'b0;
        bus.cc       = 1'b0;
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", {27'd0, bus.count}, 32'd0);
        chk("rst_full", {31'd0, bus.add_count_f}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.rd_data}, 32'd0);
        chk("rst_last", {31'd0, bus.rd_last}, 32'd0);
`ifdef ADQ_SAMPLE_BUFFER_OVF_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 5'(i + 1), (i == 15), 1'b0));
        end
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h20, 5'd16, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 5'(i + 1), 1'b0, 1'b0));
        end
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h77, 5'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0));

        foreach (vecs[k]) begin
            bus.wr       = vecs[k].wr;
            bus.cc       = vecs[k].cc;
            bus.rd_start = vecs[k].rd_start;
            bus.adc_data = vecs[k].data;
            cycle();
            bus.wr       = 1'b0;
            bus.cc       = 1'b0;
            bus.rd_start = 1'b0;
            chk($sformatf("vec%0d_count", k), {27'd0, bus.count}, {27'd0, vecs[k].exp_count});
            chk($sformatf("vec%0d_full", k), {31'd0, bus.add_count_f}, {31'd0, vecs[k].exp_full});
            chk($sformatf("vec%0d_busy", k), {31'd0, bus.busy}, {31'd0, vecs[k].exp_busy});
            chk($sformatf("vec%0d_valid", k), {31'd0, bus.rd_valid}, {31'd0, vecs[k].exp_valid});
`ifdef ADQ_SAMPLE_BUFFER_OVF_EN
            chk($sformatf("vec%0d_ovf", k), {31'd0, bus.ovf}, {31'd0, vecs[k].exp_ovf});
`endif
        end
        mcnt = 0;

        // Streaming drain with rd_ready held high
        wr_word(8'hA1);
        wr_word(8'hB2);
        wr_word(8'hC3);
        drain(1'b0, 1'b0);

        // Backpressure: rd_ready toggling
        wr_word(8'h5A);
        wr_word(8'hA5);
        drain(1'b1, 1'b0);

        // cc aborts a drain in progress
        for (int i = 0; i < 4; i++) wr_word(8'(8'h30 + i));
        bus.rd_start = 1'b1;
        bus.rd_ready = 1'b0;
        cycle();
        bus.rd_start = 1'b0;
        chk("abort_pre_valid", {31'd0, bus.rd_valid}, 32'd1);
        bus.cc = 1'b1;
        cycle();
        bus.cc = 1'b0;
        chk("abort_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_count", {27'd0, bus.count}, 32'd0);
        sb.delete();
        mcnt = 0;

        // wr during drain is ignored
        wr_word(8'hD1);
        wr_word(8'hD2);
        drain(1'b0, 1'b1);
`ifdef ADQ_SAMPLE_BUFFER_OVF_EN
        chk("ovf_after_drain_wr", {31'd0, bus.ovf}, 32'd1);
        bus.cc = 1'b1;
        cycle();
        bus.cc = 1'b0;
        chk("ovf_cleared", {31'd0, bus.ovf}, 32'd0);
`endif

        // Asynchronous reset in the middle of a drain
        wr_word(8'hE1);
        wr_word(8'hE2);
        bus.rd_start = 1'b1;
        @(posedge clk);
        #2;
        bus.rd_start = 1'b0;
        chk("pre_rst_valid", {31'd0, bus.rd_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_count", {27'd0, bus.count}, 32'd0);
        chk("arst_data", {24'd0, bus.rd_data}, 32'd0);
        chk("arst_last", {31'd0, bus.rd_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mcnt = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
